// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: bundle widths, ALU opcode bit
// positions and the layout of the decode-to-execute bundle.
// Optional build macro: EX_ALIGN_CHK_EN adds the misaligned-access flag (ale)
// to the memory-stage bundle and widens it from 71 to 72 bits.
package ex_stage_pkg;

    localparam int TO_EX_DATA_WIDTH   = 150;
`ifdef EX_ALIGN_CHK_EN
    localparam int TO_MEM_DATA_WIDTH  = 72;
`else
    localparam int TO_MEM_DATA_WIDTH  = 71;
`endif
    localparam int FORWRD_DATA_WIDTH  = 38;

    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_SLT  = 2;
    localparam int ALU_SLTU = 3;
    localparam int ALU_AND  = 4;
    localparam int ALU_NOR  = 5;
    localparam int ALU_OR   = 6;
    localparam int ALU_XOR  = 7;
    localparam int ALU_SLL  = 8;
    localparam int ALU_SRL  = 9;
    localparam int ALU_SRA  = 10;
    localparam int ALU_LUI  = 11;

    // Decoded instruction as handed over by decode, MSB first.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rj_value;
        logic [31:0] rkd_value;
        logic [31:0] imm;
        logic [11:0] alu_op;
        logic        src1_is_pc;
        logic        src2_is_imm;
        logic        mem_we;
        logic        res_from_mem;
        logic [4:0]  dest;
        logic        gr_we;
    } ex_bundle_t;

endpackage

// File: rtl/ex_stage_alu.sv
// Combinational ALU for the execute stage. alu_op is one-hot; an all-zero
// opcode yields zero. Shifts use src2[4:0] as the amount.
module alu
    import ex_stage_pkg::*;
(
    input  logic [11:0] alu_op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    output logic [31:0] result
);

    logic [4:0] shamt;
    assign shamt = src2[4:0];

    // Merge the result of whichever operation is selected; unselected ones contribute zero.
    always_comb begin
        result = 32'h0;
        if (alu_op[ALU_ADD])  result = result | (src1 + src2);
        if (alu_op[ALU_SUB])  result = result | (src1 - src2);
        if (alu_op[ALU_SLT])  result = result | {31'h0, ($signed(src1) < $signed(src2))};
        if (alu_op[ALU_SLTU]) result = result | {31'h0, (src1 < src2)};
        if (alu_op[ALU_AND])  result = result | (src1 & src2);
        if (alu_op[ALU_NOR])  result = result | ~(src1 | src2);
        if (alu_op[ALU_OR])   result = result | (src1 | src2);
        if (alu_op[ALU_XOR])  result = result | (src1 ^ src2);
        if (alu_op[ALU_SLL])  result = result | (src1 << shamt);
        if (alu_op[ALU_SRL])  result = result | (src1 >> shamt);
        if (alu_op[ALU_SRA])  result = result | $unsigned($signed(src1) >>> shamt);
        if (alu_op[ALU_LUI])  result = result | src2;
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: holds one decoded instruction, computes its ALU result,
// issues a single data-SRAM request for loads/stores and hands the result to
// the memory stage. Optional build macro EX_ALIGN_CHK_EN suppresses requests
// for misaligned word accesses and flags them with ale.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ID_to_EX_valid,
    input  logic [TO_EX_DATA_WIDTH-1:0]   to_EX_data,
    output logic                          EX_allow_in,
    input  logic                          MEM_allow_in,
    output logic                          EX_to_MEM_valid,
    output logic [TO_MEM_DATA_WIDTH-1:0]  to_MEM_data,
    output logic [FORWRD_DATA_WIDTH-1:0]  EX_forward,
    output logic                          data_sram_req,
    output logic                          data_sram_wr,
    output logic [3:0]                    data_sram_wstrb,
    output logic [31:0]                   data_sram_addr,
    output logic [31:0]                   data_sram_wdata,
    input  logic                          data_sram_addr_ok
);

    ex_bundle_t  ex_q;
    logic        ex_valid;
    logic        req_done;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] alu_result;
    logic        mem_op;
    logic        ale;
    logic        gr_we_out;
    logic        ready_go;
    logic        leave;

    assign src1 = ex_q.src1_is_pc  ? ex_q.pc  : ex_q.rj_value;
    assign src2 = ex_q.src2_is_imm ? ex_q.imm : ex_q.rkd_value;

    alu u_alu (
        .alu_op (ex_q.alu_op),
        .src1   (src1),
        .src2   (src2),
        .result (alu_result)
    );

    assign mem_op = ex_q.mem_we | ex_q.res_from_mem;

`ifdef EX_ALIGN_CHK_EN
    assign ale = mem_op & (alu_result[1:0] != 2'b00);
`else
    assign ale = 1'b0;
`endif

    // A misaligned access never reaches the SRAM and needs no handshake to leave.
    assign data_sram_req   = ex_valid & mem_op & ~req_done & ~ale;
    assign ready_go        = ~mem_op | req_done | data_sram_addr_ok | ale;
    assign EX_allow_in     = ~ex_valid | (ready_go & MEM_allow_in);
    assign EX_to_MEM_valid = ex_valid & ready_go;
    assign leave           = EX_to_MEM_valid & MEM_allow_in;
    assign gr_we_out       = ex_q.gr_we & ~ale;

    assign data_sram_wr    = ex_q.mem_we;
    assign data_sram_wstrb = {4{ex_q.mem_we}};
    assign data_sram_addr  = alu_result;
    assign data_sram_wdata = ex_q.rkd_value;

`ifdef EX_ALIGN_CHK_EN
    assign to_MEM_data = {ex_q.pc, alu_result, ex_q.res_from_mem, ex_q.dest, gr_we_out, ale};
`else
    assign to_MEM_data = {ex_q.pc, alu_result, ex_q.res_from_mem, ex_q.dest, gr_we_out};
`endif

    // Decode stalls on is_load, so the forwarded value is only ever an ALU result.
    assign EX_forward = {ex_q.dest & {5{ex_valid & gr_we_out}}, alu_result, ex_valid & ex_q.res_from_mem};

    // Stage occupancy follows the upstream valid whenever a slot opens.
    always_ff @(posedge clk) begin
        if (reset)
            ex_valid <= 1'b0;
        else if (EX_allow_in)
            ex_valid <= ID_to_EX_valid;
    end

    // Payload register; cleared on reset so every output starts at zero.
    always_ff @(posedge clk) begin
        if (reset)
            ex_q <= '0;
        else if (ID_to_EX_valid && EX_allow_in)
            ex_q <= ex_bundle_t'(to_EX_data);
    end

    // Remember an accepted request while the memory stage is busy so it is never reissued.
    always_ff @(posedge clk) begin
        if (reset)
            req_done <= 1'b0;
        else if (leave)
            req_done <= 1'b0;
        else if (data_sram_req && data_sram_addr_ok && !MEM_allow_in)
            req_done <= 1'b1;
    end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed scenarios followed by random
// instructions under random back-pressure, with a scoreboard monitor that
// checks every memory request and every result leaving the stage.
`timescale 1ns/1ps
module tb_ex_stage;
    import ex_stage_pkg::*;

    typedef struct {
        logic [TO_MEM_DATA_WIDTH-1:0] toMem;
        logic [37:0]                  fwd;
    } expOut_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wr;
        logic [3:0]  wstrb;
    } expReq_t;

    logic                         clk;
    logic                         reset;
    logic                         ID_to_EX_valid;
    logic [TO_EX_DATA_WIDTH-1:0]  to_EX_data;
    logic                         EX_allow_in;
    logic                         MEM_allow_in;
    logic                         EX_to_MEM_valid;
    logic [TO_MEM_DATA_WIDTH-1:0] to_MEM_data;
    logic [FORWRD_DATA_WIDTH-1:0] EX_forward;
    logic                         data_sram_req;
    logic                         data_sram_wr;
    logic [3:0]                   data_sram_wstrb;
    logic [31:0]                  data_sram_addr;
    logic [31:0]                  data_sram_wdata;
    logic                         data_sram_addr_ok;

    logic randomEnv;
    logic memAllowDir, memAllowRnd;
    logic addrOkDir, addrOkRnd;

    int vectors;
    int miscompares;
    int reqCycles;

    expOut_t outQ[$];
    expReq_t reqQ[$];

    assign MEM_allow_in      = randomEnv ? memAllowRnd : memAllowDir;
    assign data_sram_addr_ok = randomEnv ? addrOkRnd : addrOkDir;

    ex_stage dut (
        .clk               (clk),
        .reset             (reset),
        .ID_to_EX_valid    (ID_to_EX_valid),
        .to_EX_data        (to_EX_data),
        .EX_allow_in       (EX_allow_in),
        .MEM_allow_in      (MEM_allow_in),
        .EX_to_MEM_valid   (EX_to_MEM_valid),
        .to_MEM_data       (to_MEM_data),
        .EX_forward        (EX_forward),
        .data_sram_req     (data_sram_req),
        .data_sram_wr      (data_sram_wr),
        .data_sram_wstrb   (data_sram_wstrb),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wdata   (data_sram_wdata),
        .data_sram_addr_ok (data_sram_addr_ok)
    );

    // Free-running clock, rising edge active.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Random back-pressure and address acceptance, changed just after each rising edge.
    initial begin
        memAllowRnd = 1'b1;
        addrOkRnd   = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            memAllowRnd = ($urandom_range(0, 3) != 0);
            addrOkRnd   = ($urandom_range(0, 2) != 0);
        end
    end

    // Hard stop in case something blocks forever.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [79:0] act, input logic [79:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic flagFailure(input string name);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s: got event, expected none", name);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Reference ALU: the arithmetic each one-hot opcode stands for.
    function automatic logic [31:0] refAlu(input logic [11:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        case (op)
            12'h001: return a + b;
            12'h002: return a - b;
            12'h004: return (sa < sb) ? 32'd1 : 32'd0;
            12'h008: return (a < b) ? 32'd1 : 32'd0;
            12'h010: return a & b;
            12'h020: return ~(a | b);
            12'h040: return a | b;
            12'h080: return a ^ b;
            12'h100: return a << b[4:0];
            12'h200: return a >> b[4:0];
            12'h400: return sa >>> b[4:0];
            12'h800: return b;
            default: return 32'h0;
        endcase
    endfunction

    function automatic ex_bundle_t makeInstr(input logic [31:0] pc, input logic [31:0] rj, input logic [31:0] rkd,
                                             input logic [31:0] imm, input logic [11:0] op, input logic s1pc,
                                             input logic s2imm, input logic we, input logic ld,
                                             input logic [4:0] dest, input logic grwe);
        ex_bundle_t b;
        b.pc = pc; b.rj_value = rj; b.rkd_value = rkd; b.imm = imm; b.alu_op = op;
        b.src1_is_pc = s1pc; b.src2_is_imm = s2imm; b.mem_we = we; b.res_from_mem = ld;
        b.dest = dest; b.gr_we = grwe;
        return b;
    endfunction

    function automatic ex_bundle_t randomInstr();
        ex_bundle_t b;
        int k;
        int kind;
        k    = $urandom_range(0, 12);
        kind = $urandom_range(0, 3);
        b.pc = $urandom; b.rj_value = $urandom; b.rkd_value = $urandom; b.imm = $urandom;
        b.alu_op      = (k == 12) ? 12'h000 : 12'(1 << k);
        b.src1_is_pc  = $urandom_range(0, 1) != 0;
        b.src2_is_imm = $urandom_range(0, 1) != 0;
        b.mem_we       = (kind == 1);
        b.res_from_mem = (kind == 0);
        b.dest  = 5'($urandom_range(0, 31));
        b.gr_we = $urandom_range(0, 1) != 0;
        return b;
    endfunction

    // Present one instruction, wait until EX accepts it and record what it must produce.
    task automatic applyStimulus(input ex_bundle_t b);
        logic        accepted;
        logic [31:0] s1, s2, res;
        logic        memOp, misal, grwe;
        expOut_t     eo;
        expReq_t     er;
        accepted = 1'b0;
        ID_to_EX_valid = 1'b1;
        to_EX_data     = b;
        for (int w = 0; w < 200; w++) begin
            @(negedge clk);
            if (EX_allow_in) begin
                accepted = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!accepted) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL accept_timeout: got allow_in=0 for 200 cycles, expected 1");
        end else begin
            s1    = b.src1_is_pc ? b.pc : b.rj_value;
            s2    = b.src2_is_imm ? b.imm : b.rkd_value;
            res   = refAlu(b.alu_op, s1, s2);
            memOp = b.mem_we || b.res_from_mem;
`ifdef EX_ALIGN_CHK_EN
            misal = memOp && (res % 4 != 0);
`else
            misal = 1'b0;
`endif
            grwe = b.gr_we && !misal;
`ifdef EX_ALIGN_CHK_EN
            eo.toMem = {b.pc, res, b.res_from_mem, b.dest, grwe, misal};
`else
            eo.toMem = {b.pc, res, b.res_from_mem, b.dest, grwe};
`endif
            eo.fwd = {grwe ? b.dest : 5'd0, res, b.res_from_mem};
            outQ.push_back(eo);
            if (memOp && !misal) begin
                er.addr  = res;
                er.wdata = b.rkd_value;
                er.wr    = b.mem_we;
                er.wstrb = b.mem_we ? 4'hf : 4'h0;
                reqQ.push_back(er);
            end
        end
        @(posedge clk);
        #1;
        ID_to_EX_valid = 1'b0;
    endtask

    // Scoreboard monitor: compares accepted requests and departing results against the queues.
    initial begin
        expOut_t eo;
        expReq_t er;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (data_sram_req && data_sram_addr_ok) begin
                    if (reqQ.size() == 0) begin
                        flagFailure("unexpected_sram_req");
                    end else begin
                        er = reqQ.pop_front();
                        checkOutput("req_addr",  80'(data_sram_addr),  80'(er.addr));
                        checkOutput("req_wdata", 80'(data_sram_wdata), 80'(er.wdata));
                        checkOutput("req_wr",    80'(data_sram_wr),    80'(er.wr));
                        checkOutput("req_wstrb", 80'(data_sram_wstrb), 80'(er.wstrb));
                    end
                end
                if (EX_to_MEM_valid) begin
                    if (outQ.size() == 0) begin
                        flagFailure("unexpected_ex_to_mem_valid");
                    end else begin
                        checkOutput("ex_forward", 80'(EX_forward), 80'(outQ[0].fwd));
                        if (MEM_allow_in) begin
                            eo = outQ.pop_front();
                            checkOutput("to_mem_data", 80'(to_MEM_data), 80'(eo.toMem));
                        end
                    end
                end
            end
        end
    end

    // Directed scenarios, then random traffic, then drain and summary.
    initial begin
        logic [11:0] tOp[4];
        logic [31:0] tA[4];
        logic [31:0] tB[4];
        logic [31:0] tExp[4];
        string       tName[4];

        vectors = 0; miscompares = 0; reqCycles = 0;
        randomEnv = 1'b0; memAllowDir = 1'b1; addrOkDir = 1'b0;
        ID_to_EX_valid = 1'b0; to_EX_data = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        checkOutput("reset_allow_in",  80'(EX_allow_in),     80'd1);
        checkOutput("reset_valid",     80'(EX_to_MEM_valid), 80'd0);
        checkOutput("reset_req",       80'(data_sram_req),   80'd0);
        checkOutput("reset_forward",   80'(EX_forward),      80'd0);
        checkOutput("reset_to_mem",    80'(to_MEM_data),     80'd0);
        checkOutput("reset_wstrb",     80'(data_sram_wstrb), 80'd0);
        nextCycle();

        // add overflowing into the sign bit, leaves after one cycle
        applyStimulus(makeInstr(32'h1c000000, 32'h7fffffff, 32'h1, 32'h0, 12'h001, 0, 0, 0, 0, 5'd5, 1));
        @(negedge clk);
        checkOutput("add_valid",   80'(EX_to_MEM_valid), 80'd1);
        checkOutput("add_forward", 80'(EX_forward),      80'({5'd5, 32'h80000000, 1'b0}));
        @(negedge clk);
        checkOutput("add_left",     80'(EX_to_MEM_valid), 80'd0);
        checkOutput("add_fwd_idle", 80'({EX_forward[37:33], EX_forward[0]}), 80'd0);
        nextCycle();

        tOp[0] = 12'h004; tA[0] = 32'hffffffff; tB[0] = 32'h1; tExp[0] = 32'h1;        tName[0] = "slt";
        tOp[1] = 12'h008; tA[1] = 32'hffffffff; tB[1] = 32'h1; tExp[1] = 32'h0;        tName[1] = "sltu";
        tOp[2] = 12'h400; tA[2] = 32'h80000000; tB[2] = 32'h4; tExp[2] = 32'hf8000000; tName[2] = "sra";
        tOp[3] = 12'h800; tA[3] = 32'h0; tB[3] = 32'h12345000; tExp[3] = 32'h12345000; tName[3] = "lui";
        for (int i = 0; i < 4; i++) begin
            applyStimulus(makeInstr(32'h1c000010, tA[i], 32'h0, tB[i], tOp[i], 0, 1, 0, 0, 5'd3, 1));
            @(negedge clk);
            checkOutput(tName[i], 80'(EX_forward[32:1]), 80'(tExp[i]));
            nextCycle();
        end

        // st.w held for three cycles without addr_ok
        addrOkDir = 1'b0; memAllowDir = 1'b1; reqCycles = 0;
        applyStimulus(makeInstr(32'h1c000020, 32'h100, 32'hdeadbeef, 32'h0, 12'h001, 0, 1, 1, 0, 5'd0, 0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (data_sram_req) reqCycles++;
            checkOutput("st_wait_wstrb", 80'(data_sram_wstrb), 80'hf);
            checkOutput("st_wait_valid", 80'(EX_to_MEM_valid), 80'd0);
            checkOutput("st_wait_allow", 80'(EX_allow_in),     80'd0);
            nextCycle();
        end
        addrOkDir = 1'b1;
        @(negedge clk);
        if (data_sram_req) reqCycles++;
        checkOutput("st_ok_valid", 80'(EX_to_MEM_valid), 80'd1);
        checkOutput("st_ok_allow", 80'(EX_allow_in),     80'd1);
        nextCycle();
        addrOkDir = 1'b0;
        @(negedge clk);
        if (data_sram_req) reqCycles++;
        checkOutput("st_req_cycles", 80'(reqCycles), 80'd4);
        nextCycle();

        // ld.w accepted while the memory stage is busy for two cycles
        addrOkDir = 1'b1; memAllowDir = 1'b0; reqCycles = 0;
        applyStimulus(makeInstr(32'h1c000030, 32'h200, 32'h0, 32'h8, 12'h001, 0, 1, 0, 1, 5'd9, 1));
        @(negedge clk);
        if (data_sram_req) reqCycles++;
        checkOutput("ld_c1_is_load", 80'(EX_forward[0]), 80'd1);
        checkOutput("ld_c1_allow",   80'(EX_allow_in),   80'd0);
        nextCycle();
        @(negedge clk);
        if (data_sram_req) reqCycles++;
        checkOutput("ld_c2_req",     80'(data_sram_req), 80'd0);
        checkOutput("ld_c2_is_load", 80'(EX_forward[0]), 80'd1);
        nextCycle();
        memAllowDir = 1'b1;
        @(negedge clk);
        if (data_sram_req) reqCycles++;
        checkOutput("ld_c3_valid",   80'(EX_to_MEM_valid), 80'd1);
        checkOutput("ld_c3_is_load", 80'(EX_forward[0]),   80'd1);
        nextCycle();
        @(negedge clk);
        checkOutput("ld_left",       80'(EX_to_MEM_valid), 80'd0);
        checkOutput("ld_req_cycles", 80'(reqCycles),       80'd1);
        nextCycle();

        // reset while a load request is outstanding
        addrOkDir = 1'b0; memAllowDir = 1'b1;
        applyStimulus(makeInstr(32'h1c000040, 32'h300, 32'h0, 32'h0, 12'h001, 0, 1, 0, 1, 5'd4, 1));
        @(negedge clk);
        checkOutput("rst_pre_req", 80'(data_sram_req), 80'd1);
        nextCycle();
        reset = 1'b1;
        outQ.delete();
        reqQ.delete();
        nextCycle();
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid_valid", 80'(EX_to_MEM_valid), 80'd0);
        checkOutput("rst_mid_req",   80'(data_sram_req),   80'd0);
        checkOutput("rst_mid_allow", 80'(EX_allow_in),     80'd1);
        nextCycle();

        // ld.w to a misaligned word address
        addrOkDir = 1'b1; memAllowDir = 1'b1;
        applyStimulus(makeInstr(32'h1c000050, 32'h100, 32'h0, 32'h2, 12'h001, 0, 1, 0, 1, 5'd7, 1));
        @(negedge clk);
`ifdef EX_ALIGN_CHK_EN
        checkOutput("ale_req",   80'(data_sram_req),   80'd0);
        checkOutput("ale_valid", 80'(EX_to_MEM_valid), 80'd1);
        checkOutput("ale_flag",  80'(to_MEM_data[0]),  80'd1);
        checkOutput("ale_gr_we", 80'(to_MEM_data[1]),  80'd0);
`else
        checkOutput("misal_req",   80'(data_sram_req),   80'd1);
        checkOutput("misal_addr",  80'(data_sram_addr),  80'h102);
        checkOutput("misal_valid", 80'(EX_to_MEM_valid), 80'd1);
`endif
        nextCycle();

        // random traffic under random back-pressure
        randomEnv = 1'b1;
        for (int n = 0; n < 300; n++) begin
            repeat ($urandom_range(0, 2)) nextCycle();
            applyStimulus(randomInstr());
        end
        for (int w = 0; w < 1000; w++) begin
            if (outQ.size() == 0 && reqQ.size() == 0) break;
            @(negedge clk);
        end
        checkOutput("drain_out_queue", 80'(outQ.size()), 80'd0);
        checkOutput("drain_req_queue", 80'(reqQ.size()), 80'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the five-stage in-order pipeline, between the decode stage and the memory stage. Latches the decoded bundle through a valid/allow-in handshake, computes the ALU result, and issues data-SRAM requests for `ld.w` and `st.w` using an address/accept handshake. Drives the EX forwarding bundle back to decode, and passes the result bundle on to the memory stage.

## Interface
- No parameters; all widths come from `constants.h`.
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- ID_to_EX_valid  in  1  decode holds a valid instruction
- to_EX_data  in  `to_EX_data_width` (150)  {pc, rj_value, rkd_value, imm, alu_op[11:0], src1_is_pc, src2_is_imm, mem_we, res_from_mem, dest[4:0], gr_we}, MSB first
- EX_allow_in  out  1  EX can accept an instruction this cycle
- MEM_allow_in  in  1  memory stage can accept
- EX_to_MEM_valid  out  1  EX result is valid and ready to leave
- to_MEM_data  out  `to_MEM_data_width` (71, or 72 with the alignment check)  {pc, alu_result, res_from_mem, dest[4:0], gr_we[, ale]}
- EX_forward  out  38  {fwd_dest[4:0], alu_result[31:0], is_load}
- data_sram_req  out  1  memory request
- data_sram_wr  out  1  1 = store
- data_sram_wstrb  out  4  byte enables; 4'hf for stores, 0 for loads
- data_sram_addr  out  32  alu_result
- data_sram_wdata  out  32  rkd_value
- data_sram_addr_ok  in  1  request accepted this cycle

## Operation
- src1 = src1_is_pc ? pc : rj_value; src2 = src2_is_imm ? imm : rkd_value.
- ALU result is one-hot on alu_op:
  - bit 0 add, bit 1 sub, bit 2 slt (signed), bit 3 sltu.
  - bit 4 and, bit 5 nor, bit 6 or, bit 7 xor.
  - bits 8/9/10 sll/srl/sra; shift amount is src2[4:0].
  - bit 11 lui, result = src2.
  - All arithmetic is 32-bit, wraps, no overflow flag. All-zero alu_op gives result 0.
- mem_op = mem_we | res_from_mem.
- data_sram_req = EX_valid & mem_op & ~req_done. data_sram_wr = mem_we.
- req_done register:
  - Set when data_sram_req & data_sram_addr_ok & ~MEM_allow_in.
  - Cleared when the instruction leaves EX, and on reset.
  - A request is therefore never reissued for the same instruction.
- EX_ready_go = ~mem_op | req_done | data_sram_addr_ok.
- EX_allow_in = ~EX_valid | (EX_ready_go & MEM_allow_in).
- EX_to_MEM_valid = EX_valid & EX_ready_go.
- EX_valid loads ID_to_EX_valid when EX_allow_in. The data register latches to_EX_data when ID_to_EX_valid & EX_allow_in and holds otherwise.
- EX_forward:
  - fwd_dest = dest & {5{EX_valid & gr_we}}.
  - is_load = EX_valid & res_from_mem.
  - Decode stalls on is_load, so a load value is never forwarded from EX.

## Timing
- Reset values:
  - EX_valid = 0 and req_done = 0.
  - All outputs 0 except EX_allow_in = 1.
  - Data payload is don't-care.
- Latency for non-memory ops: 1 cycle (enter on edge N, leave on edge N+1 when MEM_allow_in).
- Memory op with addr_ok asserted on the first cycle: also 1 cycle. Each cycle without addr_ok adds one stall cycle.
- addr_ok and MEM_allow_in both high in the same cycle: the instruction leaves and req_done stays 0.
- addr_ok high but MEM_allow_in low: req_done = 1, data_sram_req drops next cycle, and EX holds until MEM_allow_in.
- Reset mid-request: data_sram_req is 0 from the cycle after the reset edge. The memory side discards any unaccepted request.
- data_sram_addr_ok while data_sram_req = 0 is ignored.

## Configuration
- EX_ALIGN_CHK_EN defined:
  - ale = mem_op & (alu_result[1:0] != 0), appended as the LSB of to_MEM_data; `to_MEM_data_width` becomes 72.
  - When ale is set: data_sram_req is forced to 0, EX_ready_go = 1, and the forwarded/exported gr_we is 0.
- EX_ALIGN_CHK_EN undefined: no ale bit, width 71, and misaligned addresses go to SRAM unchanged.

## Structure
- `constants.h` holds the width macros:
  - `to_EX_data_width` and `to_MEM_data_width` (conditional on EX_ALIGN_CHK_EN).
  - `forwrd_data_width`.
  - The alu_op bit indices.
- One sub-module: `alu` (combinational; alu_op, src1, src2 -> result). All handshake and request logic stays in ex_stage.

## Test plan
- add, src1 = 0x7fffffff, src2 = 1 -> alu_result 0x80000000. Forward dest = rd, is_load = 0. Leaves after 1 cycle.
- slt 0xffffffff vs 1 -> 1. sltu on the same operands -> 0. sra 0x80000000 by 4 -> 0xf8000000. lui imm 0x12345000 -> 0x12345000.
- st.w to addr 0x100 with wdata 0xdeadbeef, addr_ok low for 3 cycles then high:
  - req held 4 cycles with wstrb 4'hf.
  - EX_to_MEM_valid only in the addr_ok cycle; EX_allow_in low for 3 cycles.
- ld.w with addr_ok high and MEM_allow_in low for 2 cycles:
  - Exactly one req cycle, then req 0.
  - is_load = 1 throughout; leaves when MEM_allow_in rises.
- Reset asserted during a stalled ld.w request -> next cycle EX_valid = 0, req = 0, EX_allow_in = 1.
- With EX_ALIGN_CHK_EN, ld.w to addr 0x102 -> no req, ale = 1, gr_we 0, leaves in 1 cycle. Without the macro -> req issued with addr 0x102.
